// File: rtl/alu_exec_unit.sv
// alu_exec_unit: sequential front-end for the combinational 8-bit ALU.
// It accepts one instruction per in_valid/in_ready handshake and reads its operands
// from an internal register bank. It drives the ALU for one cycle, captures the
// result and flags, optionally writes the result back, and holds the result on an
// out_valid/out_ready port until the consumer takes it.
// Optional feature macro: ALU_EXEC_IMM_EN adds in_use_imm/in_imm. When in_use_imm
// is set, an 8-bit immediate replaces operand B.
module alu_exec_unit #(
    parameter int unsigned  NUM_REGS   = 4,
    parameter logic [7:0]   FLAGS_MASK = 8'h3F,
    localparam int unsigned REG_AW     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_dst,
    input  logic [REG_AW-1:0] in_src,
    input  logic              in_wb,
`ifdef ALU_EXEC_IMM_EN
    input  logic              in_use_imm,
    input  logic [7:0]        in_imm,
`endif
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    output logic [7:0]        alu_cpu_flags,
    input  logic [7:0]        alu_c,
    input  logic [7:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_result,
    output logic [7:0]        out_flags,
    output logic [REG_AW-1:0] out_dst,
    output logic [7:0]        flags_q,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [REG_AW-1:0] src_q, src_d;
    logic              wb_q, wb_d;
    logic [7:0]        result_q, result_d;
    logic [7:0]        rflags_q, rflags_d;
    logic [REG_AW-1:0] rdst_q, rdst_d;
    logic [7:0]        flags_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic [7:0]        opb;
    logic              accept;
    logic              is_exec;

    assign in_ready   = (state_q == ST_IDLE) & ~rst;
    assign accept     = in_valid & in_ready;
    assign is_exec    = (state_q == ST_EXEC);
    assign out_valid  = (state_q == ST_RESP);
    assign out_result = result_q;
    assign out_flags  = rflags_q;
    assign out_dst    = rdst_q;
    assign dbg_data   = regs_q[dbg_addr];

`ifdef ALU_EXEC_IMM_EN
    logic       use_imm_q, use_imm_d;
    logic [7:0] imm_q, imm_d;

    // Immediate operand fields are captured with the rest of the instruction on accept.
    always_comb begin
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        if (accept) begin
            use_imm_d = in_use_imm;
            imm_d     = in_imm;
        end
    end

    // Immediate operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            use_imm_q <= 1'b0;
            imm_q     <= '0;
        end else begin
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
        end
    end

    assign opb = use_imm_q ? imm_q : regs_q[src_q];
`else
    assign opb = regs_q[src_q];
`endif

    // ALU drive: operands and op only in EXEC. The current flags are always presented.
    always_comb begin
        alu_a         = '0;
        alu_b         = '0;
        alu_op        = '0;
        alu_cpu_flags = flags_q;
        if (is_exec) begin
            alu_a  = regs_q[dst_q];
            alu_b  = opb;
            alu_op = op_q;
        end
    end

    // Sequencing and capture: latch instruction on accept, capture ALU outputs in EXEC.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src_d    = src_q;
        wb_d     = wb_q;
        result_d = result_q;
        rflags_d = rflags_q;
        rdst_d   = rdst_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = in_op;
                    dst_d   = in_dst;
                    src_d   = in_src;
                    wb_d    = in_wb;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_c;
                rflags_d = alu_flags;
                rdst_d   = dst_q;
                flags_d  = (flags_q & ~FLAGS_MASK) | (alu_flags & FLAGS_MASK);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register bank update: direct load first, EXEC writeback overrides it on the same register.
    always_comb begin
        regs_d = regs_q;
        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end
        if (is_exec && wb_q) begin
            regs_d[dst_q] = alu_c;
        end
    end

    // State registers with synchronous reset. Reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            wb_q     <= 1'b0;
            result_q <= '0;
            rflags_q <= '0;
            rdst_q   <= '0;
            flags_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            wb_q     <= wb_d;
            result_q <= result_d;
            rflags_q <= rflags_d;
            rdst_q   <= rdst_d;
            flags_q  <= flags_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit. A behavioural 8-bit ALU stands in for the real ALU.
// A register/flags model predicts every observable value of the unit.
module tb_alu_exec_unit;

    localparam int unsigned NUM_REGS   = 4;
    localparam int unsigned REG_AW     = 2;
    localparam logic [7:0]  FLAGS_MASK = 8'h3F;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [REG_AW-1:0] in_dst;
    logic [REG_AW-1:0] in_src;
    logic              in_wb;
`ifdef ALU_EXEC_IMM_EN
    logic              in_use_imm;
    logic [7:0]        in_imm;
    logic              use_imm_g;
    logic [7:0]        imm_g;
`endif
    logic              ld_en;
    logic [REG_AW-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_op;
    logic [7:0]        alu_cpu_flags;
    logic [7:0]        alu_c;
    logic [7:0]        alu_flags;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_result;
    logic [7:0]        out_flags;
    logic [REG_AW-1:0] out_dst;
    logic [7:0]        flags_q;
    logic [REG_AW-1:0] dbg_addr;
    logic [7:0]        dbg_data;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic [7:0]  m_regs [NUM_REGS];
    logic [7:0]  m_flags;

    alu_exec_unit #(.NUM_REGS(NUM_REGS), .FLAGS_MASK(FLAGS_MASK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dst(in_dst), .in_src(in_src), .in_wb(in_wb),
`ifdef ALU_EXEC_IMM_EN
        .in_use_imm(in_use_imm), .in_imm(in_imm),
`endif
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cpu_flags(alu_cpu_flags),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_dst(out_dst), .flags_q(flags_q),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {flags, result}. Flags bits 7..6 echo op[1:0] so that
    // masked versus unmasked flag paths are distinguishable.
    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        int ia, ib, ic, sa, sb, r, sr;
        logic cy, ac, ov;
        logic [7:0] c;
        ia = int'(a); ib = int'(b); ic = cin ? 1 : 0;
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        cy = 1'b0; ac = 1'b0; ov = 1'b0; sr = 0;
        case (op)
            OP_ADD: begin r = ia + ib; cy = (r > 255); ac = ((ia % 16) + (ib % 16)) > 15; sr = sa + sb; end
            OP_SUB: begin r = ia - ib; cy = (ia < ib); ac = (ia % 16) < (ib % 16); sr = sa - sb; end
            OP_ADC: begin r = ia + ib + ic; cy = (r > 255); ac = ((ia % 16) + (ib % 16) + ic) > 15; sr = sa + sb + ic; end
            OP_AND: r = ia & ib;
            OP_OR:  r = ia | ib;
            OP_XOR: r = ia ^ ib;
            OP_MOV: r = ib;
            default: r = 255 - ia;
        endcase
        if (op == OP_ADD || op == OP_SUB || op == OP_ADC) ov = (sr > 127) || (sr < -128);
        c = r[7:0];
        return {op[1:0], ov, ~^c, c[7], (c == 8'h00), ac, cy, c};
    endfunction

    assign {alu_flags, alu_c} = alu_ref(alu_op, alu_a, alu_b, alu_cpu_flags[0]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input int addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = REG_AW'(addr); ld_data = data;
        tick();
        ld_en = 1'b0;
        m_regs[addr] = data;
    endtask

    // One full instruction: accept, EXEC, RESP held for 'stall' cycles, then handshake.
    task automatic run_instr(input logic [3:0] op, input int dst, input int src, input logic wb,
                             input logic acc_ld, input int acc_addr, input logic [7:0] acc_data,
                             input logic ex_ld, input int ex_addr, input logic [7:0] ex_data,
                             input int stall);
        logic [7:0] ea, eb, ec, ef;
        logic [15:0] r;
        in_valid = 1'b1; in_op = op; in_dst = REG_AW'(dst); in_src = REG_AW'(src); in_wb = wb;
        ld_en = acc_ld; ld_addr = REG_AW'(acc_addr); ld_data = acc_data;
        out_ready = (stall == 0);
`ifdef ALU_EXEC_IMM_EN
        in_use_imm = use_imm_g; in_imm = imm_g;
`endif
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", in_ready); end
        tick();
        if (acc_ld) m_regs[acc_addr] = acc_data;
        in_valid = 1'b0; in_op = 4'($urandom); in_dst = REG_AW'($urandom); in_src = REG_AW'($urandom); in_wb = 1'($urandom);
        ld_en = ex_ld; ld_addr = REG_AW'(ex_addr); ld_data = ex_data;
        ea = m_regs[dst];
`ifdef ALU_EXEC_IMM_EN
        eb = use_imm_g ? imm_g : m_regs[src];
        in_use_imm = ~use_imm_g; in_imm = 8'($urandom);
`else
        eb = m_regs[src];
`endif
        r = alu_ref(op, ea, eb, m_flags[0]);
        ec = r[7:0]; ef = r[15:8];
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exec_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exec_ready: got %b want 0", in_ready); end
        checks++; if (alu_a !== ea) begin errors++; $display("FAIL exec_alu_a: got %h want %h", alu_a, ea); end
        checks++; if (alu_b !== eb) begin errors++; $display("FAIL exec_alu_b: got %h want %h", alu_b, eb); end
        checks++; if (alu_op !== op) begin errors++; $display("FAIL exec_alu_op: got %h want %h", alu_op, op); end
        checks++; if (alu_cpu_flags !== m_flags) begin errors++; $display("FAIL exec_cpu_flags: got %h want %h", alu_cpu_flags, m_flags); end
        tick();
        ld_en = 1'b0;
        if (ex_ld) m_regs[ex_addr] = ex_data;
        if (wb) m_regs[dst] = ec;
        m_flags = (m_flags & ~FLAGS_MASK) | (ef & FLAGS_MASK);
        for (int k = 0; k <= stall; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL resp_valid: got %b want 1 (k=%0d)", out_valid, k); end
            checks++; if (out_result !== ec) begin errors++; $display("FAIL resp_result: got %h want %h", out_result, ec); end
            checks++; if (out_flags !== ef) begin errors++; $display("FAIL resp_flags: got %h want %h", out_flags, ef); end
            checks++; if (out_dst !== REG_AW'(dst)) begin errors++; $display("FAIL resp_dst: got %0d want %0d", out_dst, dst); end
            checks++; if (flags_q !== m_flags) begin errors++; $display("FAIL resp_flags_q: got %h want %h", flags_q, m_flags); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL resp_ready: got %b want 0", in_ready); end
            checks++; if ({alu_a, alu_b, alu_op} !== 20'h0) begin errors++; $display("FAIL resp_alu_idle: got %h want 0", {alu_a, alu_b, alu_op}); end
            if (k == stall) begin
                out_ready = 1'b1; in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom); in_op = 4'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL done_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_ready: got %b want 1", in_ready); end
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_addr = REG_AW'(i);
            #1;
            checks++; if (dbg_data !== m_regs[i]) begin errors++; $display("FAIL reg_R%0d: got %h want %h", i, dbg_data, m_regs[i]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (flags_q !== 8'h00) begin errors++; $display("FAIL rst_flags_q: got %h want 00", flags_q); end
        checks++; if ({out_result, out_flags, out_dst} !== 18'h0) begin errors++; $display("FAIL rst_outputs: got %h want 0", {out_result, out_flags, out_dst}); end
        checks++; if ({alu_a, alu_b, alu_op} !== 20'h0) begin errors++; $display("FAIL rst_alu: got %h want 0", {alu_a, alu_b, alu_op}); end
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_addr = REG_AW'(i);
            #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL rst_R%0d: got %h want 00", i, dbg_data); end
            m_regs[i] = 8'h00;
        end
        m_flags = 8'h00;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_directed();
        load_reg(0, 8'hCA); load_reg(1, 8'hAA);
        run_instr(OP_AND, 0, 1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0);
        dbg_addr = 2'd0; #1;
        checks++; if (out_result !== 8'h8A) begin errors++; $display("FAIL and_result: got %h want 8a", out_result); end
        checks++; if (dbg_data !== 8'h8A) begin errors++; $display("FAIL and_R0: got %h want 8a", dbg_data); end
        load_reg(0, 8'hCA);
        run_instr(OP_ADD, 0, 1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0);
        checks++; if (out_result !== 8'h74) begin errors++; $display("FAIL add_result: got %h want 74", out_result); end
        checks++; if ({flags_q[5], flags_q[0]} !== 2'b11) begin errors++; $display("FAIL add_flags: got %h want ov=1 cy=1", flags_q); end
        load_reg(0, 8'h55); load_reg(1, 8'h55);
        run_instr(OP_SUB, 0, 1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0);
        dbg_addr = 2'd0; #1;
        checks++; if (out_result !== 8'h00) begin errors++; $display("FAIL sub_result: got %h want 00", out_result); end
        checks++; if (flags_q[2] !== 1'b1) begin errors++; $display("FAIL sub_zero: got %b want 1", flags_q[2]); end
        checks++; if (dbg_data !== 8'h55) begin errors++; $display("FAIL sub_R0_kept: got %h want 55", dbg_data); end
    endtask

    task automatic test_stall();
        load_reg(2, 8'h3C);
        run_instr(OP_XOR, 2, 0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 5);
        run_instr(OP_ADC, 3, 3, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 2);
    endtask

    task automatic test_ld_collision();
        load_reg(1, 8'h11); load_reg(3, 8'h33);
        run_instr(OP_OR, 1, 3, 1'b1, 1'b1, 3, 8'h0F, 1'b1, 1, 8'hEE, 0);
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 8'h1F) begin errors++; $display("FAIL wb_wins_R1: got %h want 1f", dbg_data); end
        run_instr(OP_OR, 1, 3, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1, 8'hEE, 0);
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 8'hEE) begin errors++; $display("FAIL ld_no_wb_R1: got %h want ee", dbg_data); end
    endtask

    task automatic test_back_to_back();
        int unsigned start;
        start = cyc;
        for (int n = 0; n < 4; n++) begin
            run_instr(4'($urandom_range(0, 7)), n, 3 - n, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 0);
        end
        checks++; if (cyc - start !== 12) begin errors++; $display("FAIL b2b_cycles: got %0d want 12", cyc - start); end
    endtask

    task automatic test_reset_mid();
        load_reg(0, 8'h77); load_reg(1, 8'h01);
        in_valid = 1'b1; in_op = OP_ADD; in_dst = 2'd0; in_src = 2'd1; in_wb = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (flags_q !== 8'h00) begin errors++; $display("FAIL midrst_flags_q: got %h want 00", flags_q); end
        checks++; if ({out_result, out_flags, out_dst} !== 18'h0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", {out_result, out_flags, out_dst}); end
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_addr = REG_AW'(i);
            #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL midrst_R%0d: got %h want 00", i, dbg_data); end
            m_regs[i] = 8'h00;
        end
        m_flags = 8'h00;
        rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_after_ready: got %b want 1", in_ready); end
    endtask

`ifdef ALU_EXEC_IMM_EN
    task automatic test_imm();
        load_reg(2, 8'h0F);
        use_imm_g = 1'b1; imm_g = 8'hFF;
        run_instr(OP_XOR, 2, 3, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1);
        use_imm_g = 1'b0;
        dbg_addr = 2'd2; #1;
        checks++; if (out_result !== 8'hF0) begin errors++; $display("FAIL imm_result: got %h want f0", out_result); end
        checks++; if (dbg_data !== 8'hF0) begin errors++; $display("FAIL imm_R2: got %h want f0", dbg_data); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, NUM_REGS - 1)),
                      int'($urandom_range(0, NUM_REGS - 1)), 1'($urandom),
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, NUM_REGS - 1)), 8'($urandom),
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, NUM_REGS - 1)), 8'($urandom),
                      int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_dst = '0; in_src = '0; in_wb = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b1; dbg_addr = '0;
        m_flags = 8'h00;
`ifdef ALU_EXEC_IMM_EN
        in_use_imm = 1'b0; in_imm = '0; use_imm_g = 1'b0; imm_g = '0;
`endif
        test_reset();
        test_directed();
        test_stall();
        test_ld_collision();
        test_back_to_back();
`ifdef ALU_EXEC_IMM_EN
        test_imm();
`endif
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
